// File: rtl/fadd_align_add_pkg.sv
// Shared widths, rounding-mode encodings and the aligned-sum bundle for the
// binary32 adder front end.
package fpu_add_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int SIG_W  = 26;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } frm_e;

    typedef struct packed {
        logic              ovf;
        logic              unf;
        logic              dz;
        logic              inv;
        logic [2:0]        frm;
        logic [EXP_W-1:0]  exp_max;
        logic              sign;
        logic [SIG_W-1:0]  frac;
        logic              carry;
    } add_bundle_t;

    // {hidden, mant, guard, round}; hidden is set for any non-zero exponent
    function automatic logic [SIG_W-1:0] ext_sig(input logic [EXP_W-1:0]  e,
                                                 input logic [MANT_W-1:0] m);
        return {(e != '0), m, 2'b00};
    endfunction

endpackage

// File: rtl/fadd_align_add_if.sv
// Operand/result handshake bundle of the adder front end.
interface fadd_align_add_if;
    import fpu_add_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [31:0]         op_a;
    logic [31:0]         op_b;
    logic [2:0]          frm_in;
    logic                out_valid;
    logic                out_ready;
    logic                ovf_out;
    logic                unf_out;
    logic                dz_out;
    logic                inv_out;
    logic [2:0]          frm_out;
    logic [EXP_W-1:0]    exp_max_out;
    logic                sign_out;
    logic [SIG_W-1:0]    frac_out;
    logic                carry_out;

    modport master (
        output in_valid, op_a, op_b, frm_in, out_ready,
        input  in_ready, out_valid, ovf_out, unf_out, dz_out, inv_out,
               frm_out, exp_max_out, sign_out, frac_out, carry_out
    );

    modport slave (
        input  in_valid, op_a, op_b, frm_in, out_ready,
        output in_ready, out_valid, ovf_out, unf_out, dz_out, inv_out,
               frm_out, exp_max_out, sign_out, frac_out, carry_out
    );

endinterface

// File: rtl/fadd_align_add_right_shift_sticky.sv
// Barrel right shift of the extended significand; every bit shifted out is
// ORed into the LSB so rounding still sees it.
module right_shift_sticky
    import fpu_add_pkg::*;
(
    input  logic [SIG_W-1:0] sig_in,
    input  logic [7:0]       amt,
    output logic [SIG_W-1:0] sig_out
);

    logic [SIG_W-1:0] v;
    logic             sticky;

    always_comb begin
        v      = sig_in;
        sticky = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            if (amt[k]) begin
                sticky = sticky | (|(v & ~({SIG_W{1'b1}} << (32'd1 << k))));
                v      = v >> (32'd1 << k);
            end
        end
        if (|amt[7:5]) begin
            sticky = sticky | (|v);
            v      = '0;
        end
        sig_out = v | {{(SIG_W-1){1'b0}}, sticky};
    end

endmodule

// File: rtl/fadd_align_add.sv
// Two-stage align/add front end of the binary32 adder: S1 picks the larger
// operand and classifies, S2 aligns, adds/subtracts and holds the bundle.
module fadd_align_add
    import fpu_add_pkg::*;
(
    input  logic CLK,
    input  logic nRST,
    input  logic flush,
    fadd_align_add_if.slave bus
);

    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [MANT_W-1:0] mant_a, mant_b;
    logic              a_big, nan_a, nan_b, inf_a, inf_b, sub_in, inv_in;
    logic              s2_load, s1_adv, in_xfer;

    logic              s1_v, s1_sign_l, s1_sub, s1_inv, s1_ovf, s1_unf;
    logic [2:0]        s1_frm;
    logic [EXP_W-1:0]  s1_exp_l, s1_d;
    logic [SIG_W-1:0]  s1_sig_l, s1_sig_s, sig_s_aligned;
    logic [SIG_W:0]    sum;

    logic              s2_v;
    add_bundle_t       s2_q, s2_next;

    assign exp_a  = bus.op_a[30:23];
    assign exp_b  = bus.op_b[30:23];
    assign mant_a = bus.op_a[22:0];
    assign mant_b = bus.op_b[22:0];
    assign a_big  = bus.op_a[30:0] >= bus.op_b[30:0];
    assign nan_a  = (&exp_a) && (|mant_a);
    assign nan_b  = (&exp_b) && (|mant_b);
    assign inf_a  = (&exp_a) && !(|mant_a);
    assign inf_b  = (&exp_b) && !(|mant_b);
    assign sub_in = bus.op_a[31] ^ bus.op_b[31];
    assign inv_in = nan_a || nan_b || (inf_a && inf_b && sub_in);

    assign s2_load      = !s2_v || bus.out_ready;
    assign s1_adv       = s1_v && s2_load;
    assign bus.in_ready = !s1_v || s2_load;
    assign in_xfer      = bus.in_valid && bus.in_ready && !flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_v      <= 1'b0;
            s1_frm    <= '0;
            s1_exp_l  <= '0;
            s1_d      <= '0;
            s1_sig_l  <= '0;
            s1_sig_s  <= '0;
            s1_sign_l <= 1'b0;
            s1_sub    <= 1'b0;
            s1_inv    <= 1'b0;
            s1_ovf    <= 1'b0;
            s1_unf    <= 1'b0;
        end else begin
            if (flush)
                s1_v <= 1'b0;
            else if (bus.in_ready)
                s1_v <= bus.in_valid;
            if (in_xfer) begin
                s1_frm    <= bus.frm_in;
                s1_exp_l  <= a_big ? exp_a : exp_b;
                s1_d      <= a_big ? exp_a - exp_b : exp_b - exp_a;
                s1_sig_l  <= a_big ? ext_sig(exp_a, mant_a) : ext_sig(exp_b, mant_b);
                s1_sig_s  <= a_big ? ext_sig(exp_b, mant_b) : ext_sig(exp_a, mant_a);
                s1_sign_l <= a_big ? bus.op_a[31] : bus.op_b[31];
                s1_sub    <= sub_in;
                s1_inv    <= inv_in;
                s1_ovf    <= (inf_a || inf_b) && !inv_in;
                s1_unf    <= (exp_a == '0) && (exp_b == '0);
            end
        end
    end

    right_shift_sticky u_align (
        .sig_in  (s1_sig_s),
        .amt     (s1_d),
        .sig_out (sig_s_aligned)
    );

    // The larger operand is chosen by magnitude, so the subtraction never borrows.
    always_comb begin
        sum             = s1_sub ? {1'b0, s1_sig_l} - {1'b0, sig_s_aligned}
                                 : {1'b0, s1_sig_l} + {1'b0, sig_s_aligned};
        s2_next         = '0;
        s2_next.ovf     = s1_ovf;
        s2_next.unf     = s1_unf;
        s2_next.inv     = s1_inv;
        s2_next.frm     = s1_frm;
        s2_next.exp_max = s1_exp_l;
        s2_next.sign    = (s1_sub && (sum == '0)) ? (s1_frm == RDN) : s1_sign_l;
        s2_next.frac    = sum[SIG_W-1:0];
        s2_next.carry   = sum[SIG_W];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s2_v <= 1'b0;
            s2_q <= '0;
        end else begin
            if (flush)
                s2_v <= 1'b0;
            else if (s2_load)
                s2_v <= s1_v;
            if (s1_adv && !flush)
                s2_q <= s2_next;
        end
    end

    assign bus.out_valid   = s2_v;
    assign bus.ovf_out     = s2_q.ovf;
    assign bus.unf_out     = s2_q.unf;
    assign bus.dz_out      = s2_q.dz;
    assign bus.inv_out     = s2_q.inv;
    assign bus.frm_out     = s2_q.frm;
    assign bus.exp_max_out = s2_q.exp_max;
    assign bus.sign_out    = s2_q.sign;
    assign bus.frac_out    = s2_q.frac;
    assign bus.carry_out   = s2_q.carry;

endmodule

// File: tb/tb_fadd_align_add.sv
// Bench for fadd_align_add: arithmetic reference model plus queue scoreboard,
// directed literal vectors, backpressure/flush sequence and random traffic.
module tb_fadd_align_add;

    logic CLK = 1'b0;
    logic nRST;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    fadd_align_add_if bus ();

    fadd_align_add dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .flush (flush),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [42:0] exp_q[$];
    logic        prev_hold = 1'b0;
    logic        prev_flush = 1'b0;
    logic [42:0] hold_vec;

    function automatic logic [42:0] dut_vec();
        return {bus.ovf_out, bus.unf_out, bus.dz_out, bus.inv_out, bus.frm_out,
                bus.exp_max_out, bus.sign_out, bus.frac_out, bus.carry_out};
    endfunction

    function automatic logic [42:0] pack(input logic ovf, unf, inv, input logic [2:0] frm,
                                         input logic [7:0] e, input logic sign,
                                         input logic [25:0] frac, input logic carry);
        return {ovf, unf, 1'b0, inv, frm, e, sign, frac, carry};
    endfunction

    // Reference: plain integer arithmetic on the significand values
    function automatic logic [42:0] model(input logic [31:0] a, b, input logic [2:0] frm);
        logic [31:0] l, s;
        longint unsigned sig_l, sig_s, sh, lost, sum;
        int d;
        logic sub, sign, inv, ovf, unf, nan_a, nan_b, inf_a, inf_b;
        if (a[30:0] >= b[30:0]) begin l = a; s = b; end
        else begin l = b; s = a; end
        sig_l = (l[30:23] != 0 ? 64'd33554432 : 64'd0) + 64'(l[22:0]) * 4;
        sig_s = (s[30:23] != 0 ? 64'd33554432 : 64'd0) + 64'(s[22:0]) * 4;
        d     = int'(l[30:23]) - int'(s[30:23]);
        sh    = sig_s >> d;
        lost  = sig_s - (sh << d);
        if (lost != 0) sh = sh | 64'd1;
        sub   = a[31] ^ b[31];
        sum   = sub ? sig_l - sh : sig_l + sh;
        sign  = (sub && sum == 0) ? (frm == 3'd2) : l[31];
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        inv   = nan_a || nan_b || (inf_a && inf_b && sub);
        ovf   = (inf_a || inf_b) && !inv;
        unf   = (a[30:23] == 0) && (b[30:23] == 0);
        return pack(ovf, unf, inv, frm, l[30:23], sign, sum[25:0], sum[26]);
    endfunction

    task automatic chk(input string nm, input logic [42:0] act, req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Scoreboard: samples the cycle's inputs/outputs mid-cycle and predicts
    // the transfers at the coming rising edge.
    always @(negedge CLK) begin
        if (!nRST) begin
            exp_q.delete();
            prev_hold <= 1'b0;
            chk("rst_out_valid", 43'(bus.out_valid), 43'd0);
            chk("rst_in_ready", 43'(bus.in_ready), 43'd1);
            chk("rst_data", dut_vec(), 43'd0);
        end else begin
            chk("in_ready", 43'(bus.in_ready), 43'((exp_q.size() < 2) || bus.out_ready));
            if (prev_hold && !prev_flush) begin
                chk("stall_valid", 43'(bus.out_valid), 43'd1);
                chk("stall_data", dut_vec(), hold_vec);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("spurious_out_valid", 43'(bus.out_valid), 43'd0);
                else if (bus.out_ready) begin
                    chk("out_data", dut_vec(), exp_q.pop_front());
                    n_out++;
                end
            end
            prev_hold  <= bus.out_valid && !bus.out_ready;
            prev_flush <= flush;
            hold_vec   <= dut_vec();
            if (flush) exp_q.delete();
            else if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.op_a, bus.op_b, bus.frm_in));
        end
    end

    task automatic send_check(input logic [31:0] a, b, input logic [2:0] f,
                              input logic [42:0] req, input string nm);
        chk({nm, "_model"}, model(a, b, f), req);
        bus.op_a = a; bus.op_b = b; bus.frm_in = f;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        @(posedge CLK); #1;
        chk({nm, "_valid"}, 43'(bus.out_valid), 43'd1);
        chk(nm, dut_vec(), req);
        @(posedge CLK); #1;
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'(8'h7F + $urandom_range(0, 3));
            default: e = 8'($urandom);
        endcase
        m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    logic [31:0] bp_ops [4];
    int          idx, n_before;

    initial begin
        nRST = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.frm_in = '0;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        @(posedge CLK); #1;

        send_check(32'h3F800000, 32'h3F800000, 3'd0, pack(0,0,0,3'd0,8'h7F,0,26'h0,1), "one_plus_one");
        send_check(32'h3F800000, 32'h40000000, 3'd0, pack(0,0,0,3'd0,8'h80,0,26'h3000000,0), "one_plus_two");
        send_check(32'h3F800000, 32'hBF800000, 3'd0, pack(0,0,0,3'd0,8'h7F,0,26'h0,0), "cancel_rne");
        send_check(32'h3F800000, 32'hBF800000, 3'd2, pack(0,0,0,3'd2,8'h7F,1,26'h0,0), "cancel_rdn");
        send_check(32'h3F800000, 32'h30800000, 3'd0, pack(0,0,0,3'd0,8'h7F,0,26'h2000001,0), "sticky_d30");
        send_check(32'h7F800000, 32'hFF800000, 3'd0, pack(0,0,1,3'd0,8'hFF,0,26'h0,0), "inf_minus_inf");
        send_check(32'h7F800000, 32'h3F800000, 3'd0, pack(1,0,0,3'd0,8'hFF,0,26'h2000001,0), "inf_plus_one");
        send_check(32'h00000001, 32'h00000000, 3'd0, pack(0,1,0,3'd0,8'h00,0,26'h4,0), "denorm_unf");

        // Backpressure: four back-to-back operands against three stalled cycles
        bp_ops[0] = 32'h3F800000; bp_ops[1] = 32'h40000000;
        bp_ops[2] = 32'h40400000; bp_ops[3] = 32'hC0800000;
        n_before = n_out; idx = 0;
        for (int c = 0; c < 16; c++) begin
            bus.out_ready = (c >= 3);
            bus.in_valid  = (idx < 4);
            if (idx < 4) begin bus.op_a = bp_ops[idx]; bus.op_b = 32'h3F000000; end
            if (c == 2) chk("bp_in_ready_drop", 43'(bus.in_ready), 43'd0);
            @(negedge CLK);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge CLK); #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", 43'(idx), 43'd4);
        chk("bp_results", 43'(n_out - n_before), 43'd4);

        // Flush with one operand in flight and one offered in the same cycle
        bus.op_a = 32'h3F800000; bus.op_b = 32'h3F800000; bus.in_valid = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b1; bus.op_a = 32'h40000000;
        @(posedge CLK); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_out_valid", 43'(bus.out_valid), 43'd0);
        @(posedge CLK); #1;
        chk("flush_drop_input", 43'(bus.out_valid), 43'd0);

        // Random traffic with occasional flush and one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.op_a      = rand_op();
            bus.op_b      = ($urandom_range(0, 7) == 0) ? {~bus.op_a[31], bus.op_a[30:0]} : rand_op();
            bus.frm_in    = 3'($urandom_range(0, 4));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 49) == 0);
            nRST          = (c != 1500);
            @(posedge CLK); #1;
        end
        nRST = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            @(posedge CLK); #1;
        end
        chk("drain_empty", 43'(exp_q.size()), 43'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fadd_align_add.md
# fadd_align_add

Two-stage pipelined front end of the single-precision FP adder. It unpacks two IEEE-754 binary32 operands, classifies special cases, and aligns the smaller-magnitude significand to the larger exponent. It then adds or subtracts the significands and registers the result bundle. That bundle drives the normalize/round stage directly: ovf/unf/dz/inv flags, frm, max exponent, sign, 26-bit fraction and carry. A valid/ready handshake sits on both sides so the adder can stall behind a busy writeback.

## Interface
Parameters:
- none; all widths are fixed by binary32.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of both pipeline stages
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- op_a, op_b  in  32  binary32 operands
- frm_in  in  3  rounding mode
- out_valid  out  1  result bundle valid
- out_ready  in  1  downstream consumes bundle
- ovf_out, unf_out, dz_out, inv_out  out  1 each  special-case flags
- frm_out  out  3  rounding mode, carried with its operands
- exp_max_out  out  8  larger biased exponent
- sign_out  out  1  result sign
- frac_out  out  26  sum significand bits [25:0]
- carry_out  out  1  sum bit 26

## Operation
- Extended significand is {hidden, mant[22:0], guard, round}, 26 bits.
  - Hidden bit is 1 for exp≠0 and 0 otherwise.
- **Stage 1 (S1)**, registered:
  - Choose the larger operand by comparing {exp, mant}. Ties select op_a.
  - Compute d = exp_L − exp_S (8-bit).
  - Compute effective subtract: sub = sign_a ^ sign_b.
  - Classify each operand as NaN, inf, or zero/denormal.
- **Stage 2 (S2)**, registered:
  - Right-shift the small significand by d. For d ≥ 26 the result is 0.
  - OR all shifted-out bits into bit 0 (sticky).
  - Form the 27-bit sum sig_L ± sig_S as {carry_out, frac_out}.
- **sign_out**:
  - Normally sign_L.
  - If sub=1 and the sum is exactly 0: sign_out = (frm==RDN).
- **Flags**:
  - inv = either operand NaN, or (inf, inf, sub).
  - ovf = either operand inf and not inv.
  - unf = both operands exp==0.
  - dz = 0 always.
- **Handshake**:
  - A transfer occurs when valid && ready.
  - A stage loads when it is empty or its contents advance the same cycle.
  - in_ready = !s1_v || (s1 advances).
  - s1 advances when !s2_v || out_ready.
  - No bubbles are inserted; order is preserved.
- **flush**: clears s1_v and s2_v. Flush wins over a simultaneous input transfer; that input is dropped.

## Timing
- Latency is 2 cycles from input transfer to out_valid, with no stall.
- Throughput is 1 per cycle.
- Outputs stay stable while out_valid && !out_ready.
- Reset values:
  - out_valid = 0.
  - in_ready = 1, combinational on the empty pipe.
  - All data/flag outputs = 0 and frm_out = 0.
- nRST asserted mid-operation discards both stages immediately.

## Structure
- Package fpu_add_pkg holds:
  - frm encodings: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4.
  - Width constants: EXP_W=8, MANT_W=23, SIG_W=26.
  - Packed struct for the S2-to-output bundle.
- Sub-module right_shift_sticky: 26-bit barrel right shift with 8-bit amount and sticky OR into the LSB.

## Test plan
- 1.0+1.0 (0x3F800000, 0x3F800000) → after 2 cycles: exp_max=0x7F, carry=1, frac=0, sign=0, flags=0.
- 1.0+2.0 (0x3F800000, 0x40000000) → exp_max=0x80, frac=0x3000000, carry=0.
- 1.0+(−1.0) → frac=0, carry=0:
  - frm=RNE gives sign=0.
  - frm=RDN gives sign=1.
- 1.0+0x30800000 (d=30) → frac=0x2000001 (sticky set), carry=0.
- Special cases:
  - 0x7F800000+0xFF800000 → inv=1.
  - 0x7F800000+0x3F800000 → ovf=1, inv=0.
  - 0x00000001+0x00000000 → unf=1.
- Backpressure:
  - Setup: 4 back-to-back inputs with out_ready low for 3 cycles.
  - in_ready drops once 2 results are held.
  - All 4 results emerge in order.
  - flush in the final cycle empties the pipe, so out_valid=0 the next cycle.
